// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: stall/bubble/set_cc generation, data-memory wait timeout, sticky halt.
// Optional feature macro: PERF_CNT_EN enables saturating stall/bubble performance counters.
module pipe_hazard_ctrl #(
    parameter int              ICODE_W = 4,
    parameter int              REG_W   = 4,
    parameter int              STAT_W  = 4,
    parameter logic [REG_W-1:0] RNONE  = 4'hF,
    parameter int              TMO_CYC = 16,
    parameter int              CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    input  logic               mem_rdy,
    output logic               F_stall,
    output logic               D_stall,
    output logic               E_stall,
    output logic               M_stall,
    output logic               W_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               W_bubble,
    output logic               set_cc,
    output logic               halted,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int WC_W = $clog2(TMO_CYC + 1);

    localparam logic [ICODE_W-1:0] I_RMMOVQ = ICODE_W'(4);
    localparam logic [ICODE_W-1:0] I_MRMOVQ = ICODE_W'(5);
    localparam logic [ICODE_W-1:0] I_OPQ    = ICODE_W'(6);
    localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'(7);
    localparam logic [ICODE_W-1:0] I_CALL   = ICODE_W'(8);
    localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(9);
    localparam logic [ICODE_W-1:0] I_PUSHQ  = ICODE_W'(10);
    localparam logic [ICODE_W-1:0] I_POPQ   = ICODE_W'(11);

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state, state_n;
    logic [WC_W-1:0] wait_cnt;
    logic            lu, rt, mp, mw, mem_op_m, m_exc, w_exc, tmo_hit;

    function automatic logic is_exc(input logic [STAT_W-1:0] s);
        return (s == STAT_W'(2)) || (s == STAT_W'(3)) || (s == STAT_W'(4));
    endfunction

    always_comb begin
        m_exc    = is_exc(m_stat);
        w_exc    = is_exc(W_stat);
        mem_op_m = (M_icode == I_RMMOVQ) || (M_icode == I_MRMOVQ) || (M_icode == I_CALL) ||
                   (M_icode == I_RET)    || (M_icode == I_PUSHQ)  || (M_icode == I_POPQ);
        lu       = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt       = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mp       = (E_icode == I_JXX) && !e_cnd;
        mw       = mem_op_m && !mem_rdy && (state == RUN);
        // Counter holds completed wait cycles; the edge that would make it TMO_CYC is the timeout.
        tmo_hit  = mw && (wait_cnt == WC_W'(TMO_CYC - 1));
    end

    always_comb begin
        state_n = state;
        if (state == RUN && (w_exc || tmo_hit))
            state_n = HALTED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            wait_cnt    <= mw ? wait_cnt + WC_W'(1) : '0;
            halted      <= halted | (state_n == HALTED);
            mem_timeout <= mem_timeout | tmo_hit;
        end
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        E_stall  = 1'b0;
        M_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_bubble = 1'b0;
        set_cc   = 1'b0;
        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else if (state == HALTED) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
        end else if (mw) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else begin
            F_stall  = lu | rt;
            D_stall  = lu;
            D_bubble = mp | (rt & !lu);
            E_bubble = mp | lu;
            M_bubble = m_exc | w_exc;
            W_stall  = w_exc;
            set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (state == RUN) begin
            if (F_stall && stall_q != '1)   stall_q  <= stall_q + CNT_W'(1);
            if (E_bubble && bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: control vector table plus multi-cycle halt/wait/reset/counter sequences.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 16;
    localparam int CW  = 32;

    // Control word order: {F_stall,D_stall,E_stall,M_stall,W_stall,D_bubble,E_bubble,M_bubble,W_bubble,set_cc}
    localparam logic [9:0] C_FS = 10'h200, C_DS = 10'h100, C_ES = 10'h080, C_MS = 10'h040,
                           C_WS = 10'h020, C_DB = 10'h010, C_EB = 10'h008, C_MB = 10'h004,
                           C_WB = 10'h002, C_CC = 10'h001;
    localparam logic [9:0] P_RST  = C_DB | C_EB | C_MB | C_WB;
    localparam logic [9:0] P_HALT = C_FS | C_DS | C_ES | C_WS | C_MB;
    localparam logic [9:0] P_MW   = C_FS | C_DS | C_ES | C_MS | C_WB;

    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, m_stat, W_stat;
    logic e_cnd, mem_rdy;
    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_bubble, E_bubble, M_bubble, W_bubble, set_cc, halted, mem_timeout;
    logic [CW-1:0] stall_cnt, bubble_cnt;
    logic [9:0] ctl;

    assign ctl = {F_stall, D_stall, E_stall, M_stall, W_stall,
                  D_bubble, E_bubble, M_bubble, W_bubble, set_cc};

    pipe_hazard_ctrl #(.ICODE_W(4), .REG_W(4), .STAT_W(4), .RNONE(4'hF), .TMO_CYC(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .m_stat(m_stat), .W_stat(W_stat), .mem_rdy(mem_rdy),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
        .set_cc(set_cc), .halted(halted), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] di, ei, mi, sa, sb, dm, ms;
        logic       cnd;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    vec_t vecs[12];
    sb_t  sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(string n, logic [3:0] di, ei, mi, sa, sb, dm, ms, logic cnd, logic [9:0] e);
        vec_t v;
        v.name = n; v.di = di; v.ei = ei; v.mi = mi; v.sa = sa; v.sb = sb;
        v.dm = dm; v.ms = ms; v.cnd = cnd; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string n, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic set_idle();
        D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_cnd = 1'b1; m_stat = 4'd1; W_stat = 4'd1; mem_rdy = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected control word queued with the stimulus, compared at the following falling edge.
    task automatic chk_ctl(input string n, input logic [9:0] e);
        sb_t s;
        s.name = n; s.exp = e;
        sbq.push_back(s);
        @(negedge clk);
        s = sbq.pop_front();
        chk(s.name, CW'(ctl), CW'(s.exp));
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        #1;
        chk("rst_ctl", CW'(ctl), CW'(P_RST));
        chk("rst_halted", CW'(halted), '0);
        chk("rst_tmo", CW'(mem_timeout), '0);
        step();
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        set_idle();
        vecs[0]  = mk("idle",        1, 1, 1, 15, 15, 15, 1, 1, 10'h000);
        vecs[1]  = mk("lu_mrmov",    1, 5, 1,  3, 15,  3, 1, 1, C_FS | C_DS | C_EB);
        vecs[2]  = mk("lu_rnone",    1, 5, 1, 15, 15, 15, 1, 1, 10'h000);
        vecs[3]  = mk("lu_pop_srcB", 1, 11, 1, 15, 2,  2, 1, 1, C_FS | C_DS | C_EB);
        vecs[4]  = mk("mp_ret_D",    9, 7, 1, 15, 15, 15, 1, 0, C_FS | C_DB | C_EB);
        vecs[5]  = mk("ret_D_only",  9, 7, 1, 15, 15, 15, 1, 1, C_FS | C_DB);
        vecs[6]  = mk("lu_ret_D",    9, 5, 1,  3, 15,  3, 1, 1, C_FS | C_DS | C_EB);
        vecs[7]  = mk("ret_M",       1, 1, 9, 15, 15, 15, 1, 1, C_FS | C_DB);
        vecs[8]  = mk("opq_madr",    1, 6, 1, 15, 15, 15, 3, 1, C_MB);
        vecs[9]  = mk("opq_ok",      1, 6, 1, 15, 15, 15, 1, 1, C_CC);
        vecs[10] = mk("opq_mins",    1, 6, 1, 15, 15, 15, 4, 1, C_MB);
        vecs[11] = mk("lu_nomatch",  1, 5, 1,  4,  6,  3, 1, 1, 10'h000);

        #1;
        chk("rst_ctl0", CW'(ctl), CW'(P_RST));
        chk("rst_halted0", CW'(halted), '0);
        chk("rst_cnt0", stall_cnt, '0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step();
            D_icode = vecs[i].di; E_icode = vecs[i].ei; M_icode = vecs[i].mi;
            d_srcA = vecs[i].sa; d_srcB = vecs[i].sb; E_dstM = vecs[i].dm;
            m_stat = vecs[i].ms; e_cnd = vecs[i].cnd;
            chk_ctl(vecs[i].name, vecs[i].exp);
        end

        // Writeback exception halts; halt is sticky after status clears.
        step();
        set_idle();
        W_stat = 4'd3;
        chk_ctl("wexc_ctl", C_MB | C_WS);
        chk("wexc_halted_pre", CW'(halted), '0);
        step();
        W_stat = 4'd1;
        chk("wexc_halted", CW'(halted), CW'(1));
        chk_ctl("halt_ctl", P_HALT);
        step();
        chk("halt_sticky", CW'(halted), CW'(1));
        chk("halt_no_tmo", CW'(mem_timeout), '0);

        // 5-cycle memory wait, then a 15-cycle wait ending with ready on the would-be timeout cycle.
        do_reset();
        step();
        M_icode = 4'd5; mem_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_ctl("mw_ctl", P_MW);
            step();
        end
        mem_rdy = 1'b1;
        chk_ctl("mw_done_ctl", 10'h000);
        step();
        mem_rdy = 1'b0;
        repeat (15) step();
        mem_rdy = 1'b1;
        step();
        chk("mw_no_tmo", CW'(mem_timeout), '0);
        chk("mw_no_halt", CW'(halted), '0);

        // Full timeout.
        do_reset();
        step();
        M_icode = 4'd5; mem_rdy = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) begin
                chk("tmo_pre", CW'(mem_timeout), '0);
                chk("tmo_pre_halt", CW'(halted), '0);
            end
        end
        chk("tmo_set", CW'(mem_timeout), CW'(1));
        chk("tmo_halt", CW'(halted), CW'(1));
        chk_ctl("tmo_ctl", P_HALT);

        // Timeout coinciding with writeback exception.
        do_reset();
        step();
        M_icode = 4'd5; mem_rdy = 1'b0;
        repeat (15) step();
        W_stat = 4'd2;
        step();
        chk("tmo_exc_tmo", CW'(mem_timeout), CW'(1));
        chk("tmo_exc_halt", CW'(halted), CW'(1));

        // Reset asserted mid-wait.
        do_reset();
        step();
        M_icode = 4'd5; mem_rdy = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        #1;
        chk("midrst_ctl", CW'(ctl), CW'(P_RST));
        chk("midrst_tmo", CW'(mem_timeout), '0);
        repeat (12) step();
        rst = 1'b0;
        step();
        mem_rdy = 1'b1;
        step();
        chk("midrst_no_tmo", CW'(mem_timeout), '0);
        chk("midrst_no_halt", CW'(halted), '0);

        // Performance counters: 3 load/use cycles then 2 mispredict cycles.
        do_reset();
        step();
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        repeat (3) step();
        set_idle();
        E_icode = 4'd7; e_cnd = 1'b0;
        repeat (2) step();
        set_idle();
`ifdef PERF_CNT_EN
        chk("perf_stall", stall_cnt, CW'(3));
        chk("perf_bubble", bubble_cnt, CW'(5));
`else
        chk("perf_stall_off", stall_cnt, '0);
        chk("perf_bubble_off", bubble_cnt, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parameterised, stateful successor to the Y86-64 pipeline control logic.
- Generates stall/bubble/set_cc controls for F, D, E, M, W from the stage fields: load/use, ret, mispredict and exception hazards.
- Adds two things the previous control did not have:
  - a variable-latency data-memory wait handshake with a timeout counter;
  - a sticky halt FSM.
- Sits beside the pipeline registers; all pipeline registers consume its outputs.

Parameters:
- ICODE_W, 4, instruction code width.
- REG_W, 4, register ID width.
- STAT_W, 4, status code width.
- RNONE, 4'hF, "no register" ID; never matches as a hazard source.
- TMO_CYC, 16, consecutive mem-wait cycles before timeout (≥2).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- D_icode  in  ICODE_W  icode in decode
- E_icode  in  ICODE_W  icode in execute
- M_icode  in  ICODE_W  icode in memory
- d_srcA  in  REG_W  decode source A
- d_srcB  in  REG_W  decode source B
- E_dstM  in  REG_W  execute-stage memory destination
- e_cnd  in  1  execute condition result
- m_stat  in  STAT_W  memory-stage status
- W_stat  in  STAT_W  writeback status
- mem_rdy  in  1  data memory completed access this cycle
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  stage hold
- D_bubble, E_bubble, M_bubble, W_bubble  out  1 each  stage inject nop
- set_cc  out  1  condition-code write enable
- halted  out  1  registered, sticky
- mem_timeout  out  1  registered, sticky
- stall_cnt  out  CNT_W  F_stall cycles
- bubble_cnt  out  CNT_W  E_bubble cycles

Behaviour:
Encodings:
- Status: AOK=1, HLT=2, ADR=3, INS=4. "exc" = value in {2,3,4}.
- Icodes: OPq=6, mrmovq=5, jxx=7, call=8, ret=9, rmmovq=4, pushq=10, popq=11.
- Memory op in M: M_icode ∈ {4,5,8,9,10,11}.

Hazard terms:
- lu (load/use) = E_icode∈{5,11} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
- rt (ret in flight) = 9 ∈ {D_icode, E_icode, M_icode}.
- mp (mispredict) = E_icode==7 && !e_cnd.
- mw (memory wait) = memory op in M && !mem_rdy && state==RUN.

Outputs in RUN state (combinational):
- mw has top priority: F/D/E/M_stall=1, W_bubble=1, all other controls 0, set_cc=0.
- Otherwise:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (rt & !lu)
  - E_bubble = mp | lu
  - M_bubble = exc(m_stat) | exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc = E_icode==6 && !exc(m_stat) && !exc(W_stat)
  - E_stall = M_stall = W_bubble = 0

FSM (registered, states RUN / HALTED):
- RUN→HALTED when exc(W_stat), or when the wait counter reaches TMO_CYC.
- HALTED is sticky until rst.
- In HALTED:
  - F/D/E/W_stall = 1
  - M_bubble = 1
  - all other controls 0, set_cc = 0
  - halted = 1 from the cycle after entry.

Wait counter:
- Width clog2(TMO_CYC+1).
- Increments each mw cycle; clears on any non-mw cycle.
- On reaching TMO_CYC: mem_timeout and halted set next edge.
- Simultaneous timeout and exc(W_stat): both HALTED; mem_timeout set.
- mem_rdy high in the same cycle the counter would hit TMO_CYC: no timeout, counter clears.

Reset (asserted, any time including mid-wait):
- state = RUN; counter, halted, mem_timeout, stall_cnt, bubble_cnt = 0.
- While rst=1: D/E/M/W_bubble = 1, all stalls = 0, set_cc = 0.

Optional Feature:
PERF_CNT_EN
- Defined:
  - stall_cnt increments on every cycle with F_stall=1.
  - bubble_cnt increments on every cycle with E_bubble=1.
  - Both saturate at all-ones and freeze in HALTED.
- Undefined: no counter registers; stall_cnt and bubble_cnt are driven to 0.

Test Plan:
- mrmovq in E, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Repeat with E_dstM=RNONE, d_srcA=RNONE -> all 0.
- jxx in E, e_cnd=0, ret in D -> D_bubble=1, E_bubble=1, F_stall=1. Same with lu also true -> D_stall=1, D_bubble=0.
- OPq in E, m_stat=3 -> set_cc=0, M_bubble=1. Next cycle W_stat=3 -> W_stall=1, halted=1 after one edge, stays 1 with W_stat back to 1.
- M_icode=5, mem_rdy=0 for 5 cycles then 1 -> F/D/E/M_stall=1 and W_bubble=1 for exactly 5 cycles, then normal. Counter clears; no timeout.
- mem_rdy held 0 with TMO_CYC=16 -> mem_timeout=1 and halted=1 after edge 16. Assert rst mid-wait at cycle 8 instead -> all registered outputs 0 and bubbles 1 immediately, no timeout.
- PERF_CNT_EN defined: 3 lu cycles plus 2 mp cycles -> stall_cnt=3, bubble_cnt=5. Undefined -> both read 0.
